// File: rtl/serial_addsub_pkg.sv
// Shared types and arithmetic helper for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the 1-bit full-add primitive.
package serial_addsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    // Returns {carry, sum} of a single-bit full add.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/sa_bit_slice.sv
// One-bit full adder with its carry flop; carry is preset on load (sub -> 1).
// Latency: sum is combinational, carry updates on each enabled edge.
// Backpressure: none, advances only when the parent asserts en.
module sa_bit_slice
    import serial_addsub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic init_carry,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic carry
);

    logic [1:0] fa;

    assign fa = full_add(a, b, carry);
    assign s  = fa[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (init) begin
            carry <= init_carry;
        end else if (en) begin
            carry <= fa[1];
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/sub, LSB first, streaming each result bit as produced.
// Latency: bits valid after edges E1..E_WIDTH, done pulse after E_(WIDTH+1).
// Backpressure: start is ignored (not queued) while busy; no downstream stall.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    sa_state_t        state, state_nxt;
    logic             load, step, finish, last;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic [CNT_W-1:0] cnt;
    logic             cin_msb;
    logic             s, carry;

    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    sa_bit_slice u_slice (
        .clk        (clk),
        .rst        (rst),
        .init       (load),
        .init_carry (sub),
        .en         (step),
        .a          (a_reg[0]),
        .b          (b_reg[0]),
        .s          (s),
        .carry      (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt       <= '0;
            cin_msb   <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            bit_valid <= step;
            bit_out   <= step & s;
            done      <= finish;
            if (load) begin
                // Subtraction is a + ~b + 1; the +1 comes from the preset carry.
                a_reg <= a;
                b_reg <= sub ? ~b : b;
                cnt   <= '0;
            end
            if (step) begin
                a_reg   <= a_reg >> 1;
                b_reg   <= b_reg >> 1;
                res_reg <= {s, res_reg[WIDTH-1:1]};
                cnt     <= cnt + 1'b1;
                if (last) begin
                    cin_msb <= carry;
                end
            end
            if (finish) begin
                sum  <= res_reg;
                cout <= carry;
                ovf  <= cin_msb ^ carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8-bit instance plus a 4-bit instance.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, bit_out, bit_valid, done, cout, ovf;
    logic [7:0] sum;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, bit_out4, bit_valid4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .bit_out(bit_out), .bit_valid(bit_valid), .done(done),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_addsub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .bit_out(bit_out4), .bit_valid(bit_valid4), .done(done4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; optionally pokes start with junk data mid-run.
    task automatic run8(input string tag, input logic s_i, input logic [7:0] a_i,
                        input logic [7:0] b_i, input logic [7:0] exp_sum,
                        input logic exp_c, input logic exp_v, input logic poke);
        int n, done_n, vcnt;
        logic [7:0] stream;
        @(negedge clk);
        sub = s_i; a = a_i; b = b_i; start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, busy, 1);
        done_n = 0; vcnt = 0; stream = '0;
        while (done_n == 0 && n < 20) begin
            if (poke && n == 3) begin
                start = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bit_valid) begin
                if (vcnt < 8) stream[vcnt] = bit_out;
                vcnt++;
            end
            if (done) begin
                done_n = n;
                check({tag, ".sum"}, sum, exp_sum);
                check({tag, ".cout"}, cout, exp_c);
                check({tag, ".ovf"}, ovf, exp_v);
                check({tag, ".busy_at_done"}, busy, 0);
            end
        end
        check({tag, ".latency"}, done_n, 10);
        check({tag, ".nvalid"}, vcnt, 8);
        check({tag, ".stream"}, stream, exp_sum);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".sum_hold"}, sum, exp_sum);
    endtask

    initial begin
        int n, last_done, ndone, vcnt4, done_n4;
        logic [3:0] stream4;

        // Reset state
        #1;
        check("rst8", {busy, bit_out, bit_valid, done, cout, ovf, sum}, 0);
        check("rst4", {busy4, bit_out4, bit_valid4, done4, cout4, ovf4, sum4}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: 5A + 3C
        run8("t1", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0);
        // 2: FF + 01, then 10 - 20
        run8("t2a", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        run8("t2b", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
        // 3: 80 - 01 with a start poke during RUN
        run8("t3", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b1);

        // 4: async reset in the 3rd RUN cycle
        @(negedge clk);
        sub = 1'b0; a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t4.rst_outs", {busy, bit_out, bit_valid, done, cout, ovf}, 0);
        check("t4.rst_sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        run8("t4b", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

        // 5: start held for 30 cycles -> done every 10 cycles
        @(negedge clk);
        sub = 1'b0; a = 8'h03; b = 8'h04; start = 1'b1;
        last_done = 0; ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                check("t5.sum", sum, 8'h07);
                check("t5.gap", i - last_done, 10);
                last_done = i;
            end
        end
        start = 1'b0;
        check("t5.ndone", ndone, 3);

        // 6: 4-bit instance, 9 + 8
        @(negedge clk);
        sub4 = 1'b0; a4 = 4'h9; b4 = 4'h8; start4 = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start4 = 1'b0;
        vcnt4 = 0; done_n4 = 0; stream4 = '0;
        while (done_n4 == 0 && n < 12) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bit_valid4) begin
                if (vcnt4 < 4) stream4[vcnt4] = bit_out4;
                vcnt4++;
            end
            if (done4) begin
                done_n4 = n;
                check("t6.sum", sum4, 4'h1);
                check("t6.cout", cout4, 1);
                check("t6.ovf", ovf4, 1);
            end
        end
        check("t6.latency", done_n4, 6);
        check("t6.nvalid", vcnt4, 4);
        check("t6.stream", stream4, 4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
